// File: rtl/sram_bist_seq_if.sv
// rtl/sram_bist_seq_if.sv - ext_sram request port bundle
interface sram_bist_seq_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  stb;
    logic                  i_rw;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_dtw;
    logic [DATA_WIDTH-1:0] dtr;
    logic                  ack;

    modport master (output stb, output i_rw, output i_addr, output i_dtw,
                    input  dtr, input  ack);
    modport slave  (input  stb, input  i_rw, input  i_addr, input  i_dtw,
                    output dtr, output ack);
endinterface

// File: rtl/sram_bist_seq.sv
// rtl/sram_bist_seq.sv - SRAM range fill/readback/compare sequencer
module sram_bist_seq #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int ADDR_STEP   = 4,
    parameter int ERR_WIDTH   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    sram_bist_seq_if.master       mem,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [DATA_WIDTH-1:0] fail_exp
);
    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX = (TIMEOUT_CYC == 0) ? '0 : TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_FIN} state_t;

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  idx;
    logic [TW-1:0]         tcnt;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]  nw_q;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] rot_q;
    logic                  abort_pend;
    logic                  pass_q;
    logic                  timeout_q;
    logic [ERR_WIDTH-1:0]  err_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [DATA_WIDTH-1:0] fail_data_q;
    logic [DATA_WIDTH-1:0] fail_exp_q;

    logic                  in_xfer;
    logic                  last;
    logic                  abort_req;
    logic                  expire;
    logic                  rd_mis;
    logic [DATA_WIDTH-1:0] addr_pat;
    logic [DATA_WIDTH-1:0] exp_data;

    assign in_xfer   = (state == S_WR) || (state == S_RD);
    assign last      = (idx == nw_q - CNT_WIDTH'(1));
    assign abort_req = abort || abort_pend;
    assign expire    = (TIMEOUT_CYC != 0) && in_xfer && !mem.ack && (tcnt == TMAX);
    assign addr_pat  = DATA_WIDTH'(cur_addr);

    // rot_q tracks rotl(seed, idx mod DATA_WIDTH) incrementally, so no modulo is needed
    always_comb begin
        exp_data = seed_q;
        case (mode_q)
            2'd0:    exp_data = seed_q;
            2'd1:    exp_data = addr_pat;
            2'd2:    exp_data = ~addr_pat;
            default: exp_data = rot_q;
        endcase
    end

    assign rd_mis = (state == S_RD) && mem.ack && (mem.dtr != exp_data);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (num_words == '0) ? S_FIN : S_WR;
            S_WR: begin
                if (mem.ack) begin
                    if (abort_req)  state_nxt = S_FIN;
                    else if (last)  state_nxt = S_RD;
                end else if (expire) begin
                    state_nxt = S_FIN;
                end
            end
            S_RD: begin
                if (mem.ack) begin
                    if (abort_req || last) state_nxt = S_FIN;
                end else if (expire) begin
                    state_nxt = S_FIN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem.stb    = in_xfer;
        mem.i_rw   = (state == S_WR);
        mem.i_addr = in_xfer ? cur_addr : '0;
        mem.i_dtw  = (state == S_WR) ? exp_data : '0;
        busy       = in_xfer;
        done       = (state == S_FIN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx         <= '0;
            tcnt        <= '0;
            mode_q      <= '0;
            seed_q      <= '0;
            base_q      <= '0;
            nw_q        <= '0;
            cur_addr    <= '0;
            rot_q       <= '0;
            abort_pend  <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_exp_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q      <= mode;
                        seed_q      <= seed;
                        base_q      <= base_addr;
                        nw_q        <= num_words;
                        idx         <= '0;
                        cur_addr    <= base_addr;
                        rot_q       <= seed;
                        tcnt        <= '0;
                        abort_pend  <= 1'b0;
                        timeout_q   <= 1'b0;
                        err_q       <= '0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                        fail_exp_q  <= '0;
                        pass_q      <= (num_words == '0);
                    end
                end
                S_WR, S_RD: begin
                    if (abort) abort_pend <= 1'b1;
                    if (mem.ack) begin
                        tcnt <= '0;
                        // Last word of either phase rewinds the walkers for the next phase
                        if (last) begin
                            idx      <= '0;
                            cur_addr <= base_q;
                            rot_q    <= seed_q;
                        end else begin
                            idx      <= idx + CNT_WIDTH'(1);
                            cur_addr <= cur_addr + ADDR_WIDTH'(ADDR_STEP);
                            rot_q    <= {rot_q[DATA_WIDTH-2:0], rot_q[DATA_WIDTH-1]};
                        end
                        if (rd_mis) begin
                            if (err_q != '1) err_q <= err_q + ERR_WIDTH'(1);
                            if (err_q == '0) begin
                                fail_addr_q <= cur_addr;
                                fail_data_q <= mem.dtr;
                                fail_exp_q  <= exp_data;
                            end
                        end
                    end else if (expire) begin
                        timeout_q <= 1'b1;
                        tcnt      <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                    // Verdict uses this cycle's outcome so pass is valid alongside done
                    if (state_nxt == S_FIN)
                        pass_q <= (err_q == '0) && !rd_mis && !expire && !(mem.ack && abort_req);
                end
                default: ;
            endcase
        end
    end

    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_exp  = fail_exp_q;
endmodule

// File: tb/tb_sram_bist_seq.sv
// tb/tb_sram_bist_seq.sv - directed bench for sram_bist_seq with a behavioural SRAM
module tb_sram_bist_seq;
    logic        CLK;
    logic        RST_N;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [31:0] seed;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] fail_addr, fail_data, fail_exp;

    sram_bist_seq_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

    sram_bist_seq #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16),
        .ADDR_STEP(4), .ERR_WIDTH(16), .TIMEOUT_CYC(16)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort), .mode(mode),
        .seed(seed), .base_addr(base_addr), .num_words(num_words), .mem(mem_if),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
        .fail_exp(fail_exp)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          t_start, t_done;

    int          lat;
    logic        stuck_en, block_en;
    logic [31:0] stuck_addr, block_addr, watch_addr;
    logic [31:0] mem_arr [0:127];
    int          wcnt = 0;
    logic [6:0]  widx;

    logic [31:0] wa [$];
    logic [31:0] wd [$];
    int          watch_cnt = 0;
    int          stb_total = 0;
    int          done_cnt  = 0;

    assign widx       = mem_if.i_addr[8:2];
    assign mem_if.dtr = (stuck_en && mem_if.i_addr == stuck_addr) ? (mem_arr[widx] & ~32'h80)
                                                                   : mem_arr[widx];
    assign mem_if.ack = mem_if.stb && (wcnt >= lat) && !(block_en && mem_if.i_addr == block_addr);

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!mem_if.stb || mem_if.ack) wcnt <= 0;
        else                           wcnt <= wcnt + 1;
        if (mem_if.stb && mem_if.ack && mem_if.i_rw) mem_arr[widx] <= mem_if.i_dtw;
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            if (mem_if.stb && mem_if.ack && mem_if.i_rw) begin
                wa.push_back(mem_if.i_addr);
                wd.push_back(mem_if.i_dtw);
            end
            if (mem_if.stb && mem_if.i_addr == watch_addr) watch_cnt <= watch_cnt + 1;
            if (mem_if.stb) stb_total <= stb_total + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Config inputs are scrambled right after start to show they are latched
    task automatic kick(input logic [1:0] m, input logic [31:0] s, input logic [31:0] b,
                        input logic [15:0] n);
        @(negedge CLK);
        mode = m; seed = s; base_addr = b; num_words = n; start = 1'b1;
        t_start = cyc;
        @(negedge CLK);
        start = 1'b0;
        mode = ~m; seed = 32'hDEAD_BEEF; base_addr = 32'h0000_0F00; num_words = 16'd3;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 4000) begin
            @(negedge CLK);
            k++;
        end
        chk("done_seen", done, 1);
        t_done = cyc;
    endtask

    task automatic settle();
        repeat (2) @(negedge CLK);
        #1;
    endtask

    int w0, d0, s0, k;

    initial begin
        RST_N = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; seed = '0;
        base_addr = '0; num_words = '0; lat = 0; stuck_en = 1'b0; block_en = 1'b0;
        stuck_addr = '0; block_addr = '0; watch_addr = 32'hFFFF_FFFF;
        repeat (3) @(negedge CLK);
        chk("rst_stb", mem_if.stb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_addr", mem_if.i_addr, 0);
        RST_N = 1'b1;

        // 1: address pattern, zero-wait memory
        w0 = wa.size();
        kick(2'd1, 32'h0, 32'h0001_0000, 16'd4);
        wait_done();
        chk("t1_done_cycle", t_done - t_start + 1, 10);
        chk("t1_pass_at_done", pass, 1);
        settle();
        chk("t1_nwrites", wa.size() - w0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_waddr", wa[w0 + i], 32'h0001_0000 + 32'(4 * i));
            chk("t1_wdata", wd[w0 + i], 32'h0001_0000 + 32'(4 * i));
        end
        chk("t1_err", err_count, 0);
        chk("t1_timeout", timeout, 0);
        chk("t1_busy", busy, 0);

        // 3: walking one across the rotation wrap; a second start mid-run is ignored
        w0 = wa.size(); d0 = done_cnt;
        kick(2'd3, 32'h1, 32'h0001_0000, 16'd34);
        repeat (3) @(negedge CLK);
        num_words = 16'd2; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done();
        chk("t3_pass", pass, 1);
        settle();
        chk("t3_nwrites", wa.size() - w0, 34);
        chk("t3_w31", wd[w0 + 31], 32'h8000_0000);
        chk("t3_w32", wd[w0 + 32], 32'h0000_0001);
        chk("t3_w33", wd[w0 + 33], 32'h0000_0002);
        chk("t3_done_once", done_cnt - d0, 1);

        // 2: bit 7 stuck low at word 3
        stuck_en = 1'b1; stuck_addr = 32'h0001_000C;
        kick(2'd0, 32'hFFFF_FFFF, 32'h0001_0000, 16'd8);
        wait_done();
        chk("t2_pass", pass, 0);
        settle();
        stuck_en = 1'b0;
        chk("t2_err", err_count, 1);
        chk("t2_fail_addr", fail_addr, 32'h0001_000C);
        chk("t2_fail_data", fail_data, 32'hFFFF_FF7F);
        chk("t2_fail_exp", fail_exp, 32'hFFFF_FFFF);

        // 4: word 2 never acked
        block_en = 1'b1; block_addr = 32'h0001_0008; watch_addr = 32'h0001_0008;
        s0 = watch_cnt; d0 = done_cnt;
        kick(2'd1, 32'h0, 32'h0001_0000, 16'd4);
        chk("t4_err_cleared", err_count, 0);
        wait_done();
        chk("t4_timeout", timeout, 1);
        chk("t4_pass", pass, 0);
        chk("t4_stb_low", mem_if.stb, 0);
        @(posedge CLK); #1;
        chk("t4_done_low", done, 0);
        settle();
        block_en = 1'b0;
        chk("t4_wait_cycles", watch_cnt - s0, 16);
        chk("t4_done_once", done_cnt - d0, 1);

        // 5: abort during a 3-cycle-latency write, then a clean restart
        lat = 3; w0 = wa.size(); s0 = watch_cnt;
        kick(2'd1, 32'h0, 32'h0001_0000, 16'd8);
        k = 0;
        while (!(mem_if.stb && mem_if.i_rw && mem_if.i_addr == 32'h0001_0008) && k < 200) begin
            @(negedge CLK);
            k++;
        end
        chk("t5_reached_w2", k < 200, 1);
        abort = 1'b1;
        wait_done();
        abort = 1'b0;
        chk("t5_pass", pass, 0);
        chk("t5_timeout_cleared", timeout, 0);
        settle();
        chk("t5_nwrites", wa.size() - w0, 3);
        chk("t5_w2_held", watch_cnt - s0, 4);
        lat = 1; w0 = wa.size(); watch_addr = 32'hFFFF_FFFF;
        kick(2'd2, 32'h0, 32'h0001_0000, 16'd4);
        wait_done();
        chk("t5r_pass", pass, 1);
        settle();
        chk("t5r_err", err_count, 0);
        chk("t5r_timeout", timeout, 0);
        chk("t5r_w0", wd[w0], 32'hFFFE_FFFF);
        chk("t5r_w3", wd[w0 + 3], 32'hFFFE_FFF3);

        // 6: reset during readback, then zero-length run
        lat = 0;
        kick(2'd0, 32'hA5A5_A5A5, 32'h0001_0000, 16'd8);
        k = 0;
        while (!(mem_if.stb && !mem_if.i_rw) && k < 200) begin
            @(negedge CLK);
            k++;
        end
        chk("t6_reached_rd", k < 200, 1);
        RST_N = 1'b0;
        #1;
        chk("t6_rst_stb", mem_if.stb, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_addr", mem_if.i_addr, 0);
        chk("t6_rst_done", done, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        s0 = stb_total;
        kick(2'd0, 32'h0, 32'h0001_0000, 16'd0);
        wait_done();
        chk("t6_zero_latency", t_done - t_start, 1);
        chk("t6_zero_pass", pass, 1);
        settle();
        chk("t6_no_stb", stb_total - s0, 0);
        chk("t6_zero_err", err_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_bist_seq.md
Name: sram_bist_seq

Overview:
- Parametrised successor of the single-word SRAM write/readback sequencer.
- Sits between board top-level control (buttons/GPIO) and the ext_sram request port (stb/i_rw/i_addr/i_dtw/dtr/ack).
- Writes a programmable pattern over a contiguous address range, reads it back, compares it, and reports pass/fail, error count and first-failure details.
- Adds runtime pattern modes, range/stride generalisation, ack timeout and abort, none of which the single-word sequencer had.

Parameters:
- ADDR_WIDTH, 32, width of request address.
- DATA_WIDTH, 32, width of write/read data.
- CNT_WIDTH, 16, width of word index and length.
- ADDR_STEP, 4, address increment per word.
- ERR_WIDTH, 16, error counter width (saturating).
- TIMEOUT_CYC, 1024, max cycles stb may wait for ack; 0 disables the timeout.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a run when idle
- abort  in  1  level; stops the run at the next safe point
- mode  in  2  pattern: 0 const seed, 1 address, 2 ~address, 3 walking (seed rotated left by index mod DATA_WIDTH)
- seed  in  DATA_WIDTH  pattern seed
- base_addr  in  ADDR_WIDTH  first word address
- num_words  in  CNT_WIDTH  words to test; 0 = none
- stb  out  1  request valid
- i_rw  out  1  1 = write, 0 = read
- i_addr  out  ADDR_WIDTH  request address
- i_dtw  out  DATA_WIDTH  write data
- dtr  in  DATA_WIDTH  read data, valid in the ack cycle
- ack  in  1  one-cycle completion pulse
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  last run had no mismatch, timeout or abort; held until next start
- timeout  out  1  last run ended by ack timeout
- err_count  out  ERR_WIDTH  mismatches in last run, saturating at all-ones
- fail_addr  out  ADDR_WIDTH  address of first mismatch
- fail_data  out  DATA_WIDTH  data read at first mismatch
- fail_exp  out  DATA_WIDTH  expected data at first mismatch

Behaviour:
- Reset (async, RST_N low):
  - All outputs are 0 and the FSM is IDLE.
  - Internal index, timeout counter and latched config are cleared.
  - Reset mid-run abandons the run immediately; stb drops asynchronously.
- Config latch:
  - On start in IDLE, latch mode, seed, base_addr and num_words.
  - Clear err_count, fail_*, pass and timeout.
  - Inputs may change freely afterwards.
  - start while busy is ignored.
- Address arithmetic:
  - word i is at addr = base_addr + i*ADDR_STEP, modulo 2^ADDR_WIDTH (wraps silently).
- Expected data:
  - mode 0: seed.
  - mode 1: addr zero-extended or truncated to DATA_WIDTH.
  - mode 2: bitwise inverse of the mode-1 value.
  - mode 3: rotl(seed, i mod DATA_WIDTH).
  - The value is a pure function of (i, addr), so it is recomputed during readback with no storage.
- FSM states:
  - IDLE: start with num_words = 0 goes to FIN. Otherwise start goes to WR with i = 0.
  - WR: stb = 1, i_rw = 1, i_addr/i_dtw driven per word i, held stable until ack.
    - On ack: if i = num_words-1, go to RD with i = 0; else increment i and stay in WR.
    - stb stays high across back-to-back words. The new address and data appear the cycle after ack.
  - RD: stb = 1, i_rw = 0, i_dtw = 0.
    - On ack, compare dtr with expected. A mismatch increments err_count, saturating.
    - If this is the first mismatch, capture fail_addr, fail_data and fail_exp.
    - The last index goes to FIN.
  - FIN: stb = 0, busy = 0, done pulses for 1 cycle, pass = (err_count == 0 && !timeout && !aborted). Then go to IDLE.
- busy is 1 in WR and RD only.
- Timeout:
  - The counter resets on each ack and on entering WR/RD, and counts cycles with stb high and no ack.
  - Reaching TIMEOUT_CYC sets timeout = 1, drops stb and goes to FIN.
- Abort:
  - Sampled in WR/RD, but only acted on when stb is low or in the ack cycle. An outstanding request is never withdrawn before ack.
  - The ack in the abort cycle still completes normally (a read is still compared).
  - Then go to FIN with pass = 0.
- Simultaneous events:
  - ack in the same cycle as timeout expiry: ack wins and the timeout counter clears.
  - start in the same cycle as the FIN done pulse is ignored.
- Latency: a run of N words with zero-wait ack takes 2N+2 cycles from start to done.
- num_words = max (all ones) is legal; the index must not overflow before the compare.

Test Plan:
1. Fill/verify, no errors.
   - Stimulus: mode 1, base 0x0001_0000, num_words 4, ideal memory model with 1-cycle ack.
   - Required: writes to 0x10000, 0x10004, 0x10008, 0x1000C with data equal to the address; reads match; done at cycle 10; pass = 1; err_count = 0.
2. Stuck-bit injection.
   - Stimulus: mode 0, seed 0xFFFF_FFFF, num_words 8, model forces bit 7 to 0 at word 3.
   - Required: err_count = 1, fail_addr = base+12, fail_data = 0xFFFF_FF7F, fail_exp = 0xFFFF_FFFF, pass = 0.
3. Walking pattern with rotation wrap.
   - Stimulus: mode 3, seed 0x1, num_words 34.
   - Required: word 31 data = 0x8000_0000, word 32 data = 0x1, word 33 data = 0x2; pass = 1.
4. Ack timeout.
   - Stimulus: TIMEOUT_CYC 16, model never acks word 2.
   - Required: stb drops after 16 waiting cycles, timeout = 1, pass = 0, done pulses once.
5. Abort and restart.
   - Stimulus: abort raised mid-write with a 3-cycle ack latency.
   - Required: stb stays high until that ack, then FIN with pass = 0. A subsequent start runs cleanly, and err_count/timeout are cleared.
6. Reset and zero length.
   - Stimulus: RST_N pulsed low mid-read.
   - Required: outputs go to 0 immediately. After release, start with num_words 0 gives done in 1 cycle, pass = 1, stb never asserted.
